phy_rx: RTL and testbench
=========================

# phy_rx

Receive-side physical layer: recovers byte alignment from the 1-bit serial stream produced by the transmit PHY at 32f, discards comma/idle bytes and demultiplexes recovered bytes back onto four 8-bit lanes with per-lane valid. Sits between the serial link and the lane consumers. It is the mirror of the transmit path (4→2→1 mux plus parallel-to-serial). Everything runs on the single 32f clock; slower-rate behaviour is produced with internal bit and lane counters.

## Interface

Parameters:
- COMMA, 8'hBC: idle/comma byte sent by the transmitter when no lane data is valid.
- LOCK_COUNT, 4: consecutive byte-aligned COMMA bytes required to declare lock.

Ports:
- clk_32f, input, 1: serial bit clock. This is the only clock.
- reset, input, 1: asynchronous, active-high reset.
- data_in, input, 1: serial stream, MSB of each byte first, one bit per clk_32f edge.
- active, output, 1: link locked. Reset value 0.
- out0..out3, output, 8 each: recovered lane bytes. Reset value 8'h00.
- valid_out0..valid_out3, output, 1 each: lane byte is data, not COMMA. Reset value 0.

## Operation

- **Shift register `sr[7:0]`**: updated every edge as `sr <= {sr[6:0], data_in}`. Reset value 0.
- **Counters**:
  - bit counter `bitcnt` (3 bits). A byte is complete when `bitcnt` wraps 7→0.
  - lane counter `lane` (2 bits).
  - comma counter `bccnt` (0..LOCK_COUNT).
- **State machine**, reset state SEARCH:
  - **SEARCH**: every cycle, compare the post-shift value `{sr[6:0], data_in}` against COMMA.
    - On a match: go to ALIGN, set `bccnt=1`, clear `bitcnt` so the next byte boundary falls 8 edges later.
  - **ALIGN**: at each byte boundary, compare the completed byte against COMMA.
    - Match: increment `bccnt`. When it reaches LOCK_COUNT, go to LOCKED, set `active=1` and set `lane=0` for the next byte.
    - Mismatch: set `bccnt=0` and return to SEARCH. Bit-level searching resumes on the next edge.
  - **LOCKED**: at each byte boundary, write the completed byte into lane buffer `buf[lane]` with `vbuf[lane] = (byte != COMMA)`, then increment `lane` (mod 4).
    - A COMMA byte stores `buf[lane]=COMMA` with valid 0.
    - LOCKED is left only through reset; there is no loss-of-lock detection.
- **Output update**: when the lane-3 byte is written, all four outputs are loaded together.
  - `out0..out3` take `buf0..buf2` plus the lane-3 byte.
  - `valid_out0..valid_out3` take the matching valid bits.
  - Outputs hold until the next frame update, 32 cycles later.
- **Lane framing rule**: the transmitter's idle stream is a whole number of 4-byte frames, so the first byte after lock is lane 0.
- **Reset mid-operation**: asynchronous return to SEARCH. All counters, buffers, outputs and `active` clear immediately, without waiting for a clock edge.

## Timing

- Byte boundary: the edge that samples bit 0 (LSB) of a byte.
  - In LOCKED, the buffer write happens on that same edge, because the byte is `{sr[6:0], data_in}`.
- Output latency: `outN`/`valid_outN` change on the clk_32f edge after the edge that sampled the LSB of the lane-3 byte (1 cycle).
  - Update period: exactly 32 clk_32f cycles once locked.
- `active` rises on the edge after the LOCK_COUNT-th aligned COMMA completes. It is stable afterwards.
- Lock acquisition from the first COMMA bit alignment: the first COMMA's LSB edge plus 8·(LOCK_COUNT−1) cycles, plus 1.
  - With a clean idle stream and LOCK_COUNT=4, that is 25 cycles after the first COMMA LSB edge.
- First frame output: 32 cycles after lock for lane bytes 0..3, plus the 1-cycle latency.

## Test plan

- **Reset and idle lock**: hold reset 3 cycles, then send continuous 8'hBC.
  - `active` stays 0 until the 4th aligned BC, then goes 1.
  - All `valid_out` stay 0; all `out` = 8'hBC after the first frame.
- **Data frame**: after lock, send bytes 8'h11, 8'h22, 8'h33, 8'h44.
  - Expect `out0..3` = 11/22/33/44 and `valid_out0..3` = 1111, updated 1 cycle after the 44 LSB.
- **Mixed valid**: after lock, send frame 8'hA5, BC, 8'h5A, BC.
  - Expect `valid_out` = 1,0,1,0 and `out1` = `out3` = 8'hBC.
- **Misaligned start**: prepend 3 random bits before the BC stream.
  - Lock is still achieved on the correct byte boundary.
  - A following frame 01/02/03/04 appears intact.
- **False comma**: send BC, BC, 8'h3C, then a continuous BC stream.
  - The FSM returns to SEARCH at 8'h3C; `active` rises only after 4 fresh consecutive BCs.
- **Async reset while locked**: assert reset mid-byte.
  - `active`, all `valid_out` and all `out` go 0 before the next clock edge.
  - After release, lock is re-acquired from SEARCH.

Source files
------------

// File: rtl/phy_rx_if.sv
// Link-side bundle of the receive PHY: serial bit input plus four recovered lanes.
interface phy_rx_if;
    logic       data_in;
    logic       active;
    logic [7:0] out0;
    logic [7:0] out1;
    logic [7:0] out2;
    logic [7:0] out3;
    logic       valid_out0;
    logic       valid_out1;
    logic       valid_out2;
    logic       valid_out3;

    modport master (
        output data_in,
        input  active, out0, out1, out2, out3,
        input  valid_out0, valid_out1, valid_out2, valid_out3
    );

    modport slave (
        input  data_in,
        output active, out0, out1, out2, out3,
        output valid_out0, valid_out1, valid_out2, valid_out3
    );
endinterface

// File: rtl/phy_rx.sv
// Receive PHY: comma-based byte alignment of a 1-bit stream at 32f and
// demultiplexing of the recovered bytes onto four lanes with per-lane valid.
module phy_rx #(
    parameter logic [7:0]  COMMA      = 8'hBC,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic     clk_32f,
    input  logic     reset,
    phy_rx_if.slave  link
);

    localparam int unsigned BCW = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t          state_r;
    // Only the seven most recent bits are kept; the eighth is the live input bit.
    logic [6:0]      sr_r;
    logic [2:0]      bitcnt_r;
    logic [1:0]      lane_r;
    logic [BCW-1:0]  bccnt_r;
    logic [3:0][7:0] lbuf_r;
    logic [3:0]      vbuf_r;
    logic            upd_r;
    logic            active_r;
    logic [3:0][7:0] out_r;
    logic [3:0]      vout_r;

    logic [7:0]      byte_s;
    logic            boundary_s;
    logic            is_comma_s;
    logic [BCW-1:0]  bccnt_inc_s;

    function automatic logic is_comma(input logic [7:0] b);
        return (b == COMMA);
    endfunction

    // Byte formed by this edge's bit, and byte-boundary detection on counter wrap.
    always_comb begin
        byte_s      = {sr_r, link.data_in};
        boundary_s  = (bitcnt_r == 3'd7);
        is_comma_s  = is_comma(byte_s);
        bccnt_inc_s = bccnt_r + BCW'(1);
    end

    // Alignment state machine, counters, lane buffers and registered outputs.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_r  <= ST_SEARCH;
            sr_r     <= 7'h00;
            bitcnt_r <= 3'd0;
            lane_r   <= 2'd0;
            bccnt_r  <= '0;
            lbuf_r   <= 32'h0000_0000;
            vbuf_r   <= 4'h0;
            upd_r    <= 1'b0;
            active_r <= 1'b0;
            out_r    <= 32'h0000_0000;
            vout_r   <= 4'h0;
        end else begin
            sr_r     <= byte_s[6:0];
            bitcnt_r <= bitcnt_r + 3'd1;
            upd_r    <= 1'b0;
            active_r <= (state_r == ST_LOCKED);

            // The lane-3 byte was written on the previous edge, so all four buffers are current.
            if (upd_r) begin
                out_r  <= lbuf_r;
                vout_r <= vbuf_r;
            end

            case (state_r)
                ST_SEARCH: begin
                    if (is_comma_s) begin
                        state_r  <= ST_ALIGN;
                        bccnt_r  <= BCW'(1);
                        bitcnt_r <= 3'd0;
                    end
                end
                ST_ALIGN: begin
                    if (boundary_s) begin
                        if (is_comma_s) begin
                            bccnt_r <= bccnt_inc_s;
                            if (bccnt_inc_s == BCW'(LOCK_COUNT)) begin
                                state_r <= ST_LOCKED;
                                lane_r  <= 2'd0;
                            end
                        end else begin
                            bccnt_r <= '0;
                            state_r <= ST_SEARCH;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (boundary_s) begin
                        lbuf_r[lane_r] <= byte_s;
                        vbuf_r[lane_r] <= ~is_comma_s;
                        lane_r         <= lane_r + 2'd1;
                        upd_r          <= (lane_r == 2'd3);
                    end
                end
                default: begin
                    state_r <= ST_SEARCH;
                end
            endcase
        end
    end

    assign link.active     = active_r;
    assign link.out0       = out_r[0];
    assign link.out1       = out_r[1];
    assign link.out2       = out_r[2];
    assign link.out3       = out_r[3];
    assign link.valid_out0 = vout_r[0];
    assign link.valid_out1 = vout_r[1];
    assign link.valid_out2 = vout_r[2];
    assign link.valid_out3 = vout_r[3];

endmodule

// File: tb/tb_phy_rx.sv
// Self-checking bench for phy_rx: bit-indexed reference model checked every cycle,
// a table of lane frames, and hand-written lock / false-comma / async-reset sequences.
module tb_phy_rx;

    localparam logic [7:0] COMMA = 8'hBC;
    localparam int         LOCKN = 4;

    logic clk;
    logic reset;
    phy_rx_if link();

    phy_rx #(.COMMA(COMMA), .LOCK_COUNT(LOCKN)) dut (
        .clk_32f (clk),
        .reset   (reset),
        .link    (link)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] bytes;   // lane0 byte in [31:24] .. lane3 byte in [7:0]
        logic [3:0]  v;       // {valid3, valid2, valid1, valid0}
    } frame_t;

    int n_cmp;
    int n_err;
    int act_seen;

    // Reference model state: every bit received since reset, indexed by edge number.
    bit         mbits[$];
    int         m_mode;       // 0 hunting, 1 counting commas, 2 locked
    int         m_anchor;
    int         m_cnt;
    int         m_lock;
    logic [7:0] m_frame[4];
    logic [3:0] m_fv;
    bit         m_pend;
    logic [7:0] e_out[4];
    logic [3:0] e_v;
    logic       e_act;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] window(input int n);
        logic [7:0] w;
        int idx;
        w = 8'h00;
        for (int k = 0; k < 8; k++) begin
            idx = n - 7 + k;
            w = {w[6:0], (idx >= 0) ? mbits[idx] : 1'b0};
        end
        return w;
    endfunction

    task automatic model_reset();
        mbits.delete();
        m_mode = 0; m_anchor = 0; m_cnt = 0; m_lock = -1; m_pend = 1'b0;
        m_fv = 4'h0; e_v = 4'h0; e_act = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_frame[i] = 8'h00;
            e_out[i]   = 8'h00;
        end
    endtask

    // Expected register contents right after edge n, where n is the index of bit b.
    task automatic model_step(input bit b);
        int n;
        int k;
        logic [7:0] w;
        mbits.push_back(b);
        n = mbits.size() - 1;
        w = window(n);
        if (m_pend) begin
            for (int i = 0; i < 4; i++) e_out[i] = m_frame[i];
            e_v    = m_fv;
            m_pend = 1'b0;
        end
        case (m_mode)
            0: begin
                if (w == COMMA) begin
                    m_mode = 1; m_anchor = n; m_cnt = 1;
                end
            end
            1: begin
                if ((n - m_anchor) % 8 == 0) begin
                    if (w == COMMA) begin
                        m_cnt++;
                        if (m_cnt == LOCKN) begin
                            m_mode = 2; m_lock = n;
                        end
                    end else begin
                        m_mode = 0;
                    end
                end
            end
            default: begin
                if ((n - m_lock) % 8 == 0) begin
                    k = (n - m_lock) / 8 - 1;
                    m_frame[k % 4] = w;
                    m_fv[k % 4]    = (w != COMMA);
                    if (k % 4 == 3) m_pend = 1'b1;
                end
            end
        endcase
        e_act = (m_lock >= 0) && (n > m_lock);
    endtask

    task automatic check_all();
        chk("cyc_active", 32'(link.active), 32'(e_act));
        chk("cyc_out0", 32'(link.out0), 32'(e_out[0]));
        chk("cyc_out1", 32'(link.out1), 32'(e_out[1]));
        chk("cyc_out2", 32'(link.out2), 32'(e_out[2]));
        chk("cyc_out3", 32'(link.out3), 32'(e_out[3]));
        chk("cyc_valid", 32'({link.valid_out3, link.valid_out2, link.valid_out1, link.valid_out0}),
            32'(e_v));
    endtask

    task automatic send_bit(input bit b);
        link.data_in = b;
        @(posedge clk);
        #1;
        model_step(b);
        check_all();
        if (act_seen < 0 && link.active === 1'b1) act_seen = mbits.size() - 1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_active"}, 32'(link.active), 32'h0);
        chk({tag, "_out0"}, 32'(link.out0), 32'h0);
        chk({tag, "_out1"}, 32'(link.out1), 32'h0);
        chk({tag, "_out2"}, 32'(link.out2), 32'h0);
        chk({tag, "_out3"}, 32'(link.out3), 32'h0);
        chk({tag, "_valid"},
            32'({link.valid_out3, link.valid_out2, link.valid_out1, link.valid_out0}), 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        link.data_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b0;
        model_reset();
        act_seen = -1;
    endtask

    // Send a frame, then the MSB of the following comma: that edge loads the outputs.
    task automatic apply_frame(input frame_t f);
        logic [7:0] c;
        c = COMMA;
        send_byte(f.bytes[31:24]);
        send_byte(f.bytes[23:16]);
        send_byte(f.bytes[15:8]);
        send_byte(f.bytes[7:0]);
        send_bit(c[7]);
        chk("frame_out0", 32'(link.out0), 32'(f.bytes[31:24]));
        chk("frame_out1", 32'(link.out1), 32'(f.bytes[23:16]));
        chk("frame_out2", 32'(link.out2), 32'(f.bytes[15:8]));
        chk("frame_out3", 32'(link.out3), 32'(f.bytes[7:0]));
        chk("frame_valid",
            32'({link.valid_out3, link.valid_out2, link.valid_out1, link.valid_out0}), 32'(f.v));
        for (int i = 6; i >= 0; i--) send_bit(c[i]);
        repeat (3) send_byte(c);
    endtask

    frame_t tbl[5];
    frame_t f_seq;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        logic [7:0] c;
        logic [7:0] rb;
        c = COMMA;
        n_cmp = 0;
        n_err = 0;
        act_seen = -1;
        reset = 1'b1;
        link.data_in = 1'b0;
        model_reset();

        tbl[0] = '{32'h11223344, 4'b1111};
        tbl[1] = '{32'hA5BC5ABC, 4'b0101};
        tbl[2] = '{32'hBCBCBCBC, 4'b0000};
        tbl[3] = '{32'hBC77BCBC, 4'b0010};
        tbl[4] = '{32'h00FFBC3C, 4'b1011};
        f_seq  = '{32'h01020304, 4'b1111};

        // Idle lock: first comma completes on edge 7, active visible on edge 7+25.
        do_reset();
        repeat (8) send_byte(c);
        chk("idle_lock_edge", 32'(act_seen), 32'd32);
        send_bit(c[7]);
        chk("idle_out0", 32'(link.out0), 32'(c));
        chk("idle_out3", 32'(link.out3), 32'(c));
        chk("idle_valid",
            32'({link.valid_out3, link.valid_out2, link.valid_out1, link.valid_out0}), 32'h0);
        for (int i = 6; i >= 0; i--) send_bit(c[i]);
        repeat (3) send_byte(c);
        for (int i = 0; i < 5; i++) apply_frame(tbl[i]);

        // Three stray bits shift every boundary by three edges.
        do_reset();
        repeat (3) send_bit(1'($urandom_range(0, 1)));
        repeat (8) send_byte(c);
        chk("misalign_lock_edge", 32'(act_seen), 32'd35);
        apply_frame(f_seq);

        // False comma: 3C breaks alignment; lock needs four fresh commas.
        do_reset();
        send_byte(c);
        send_byte(c);
        send_byte(8'h3C);
        repeat (4) send_byte(c);
        chk("false_comma_not_yet", 32'(link.active), 32'h0);
        repeat (4) send_byte(c);
        chk("false_comma_lock_edge", 32'(act_seen), 32'd56);
        apply_frame(tbl[0]);

        // Asynchronous reset mid-byte while locked.
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        chk("pre_reset_active", 32'(link.active), 32'h1);
        chk("pre_reset_out0", 32'(link.out0), 32'(c));
        #2 reset = 1'b1;
        #1;
        check_zero("async_reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        act_seen = -1;
        repeat (8) send_byte(c);
        chk("relock_edge", 32'(act_seen), 32'd32);

        // Random noise, an idle run, then random frames against the model.
        do_reset();
        repeat (20) send_bit(1'($urandom_range(0, 1)));
        repeat (8) send_byte(c);
        repeat (30) begin
            for (int j = 0; j < 4; j++) begin
                rb = ($urandom_range(0, 3) == 0) ? c : 8'($urandom);
                send_byte(rb);
            end
        end
        send_bit(1'b1);
        chk("random_locked", 32'(link.active), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
